// File: rtl/sarm_hzd_pkg.sv
// Shared types and helpers for the SARM hazard scoreboard: entry layout, bubble
// constant, writer-match helper and parameter legality check.
package sarm_hzd_pkg;

  // Entries store register addresses at a fixed maximum width; narrower REG_AW zero-extends.
  localparam int SB_AW = 8;

  typedef logic [SB_AW-1:0] sb_reg_t;

  typedef struct packed {
    logic    v;
    logic    wb_en;
    logic    mem_r_en;
    sb_reg_t dest;
    sb_reg_t src1;
    sb_reg_t src2;
    logic    two_src;
  } sb_entry_t;

  localparam int        SEL_RF    = 0;
  localparam sb_entry_t SB_BUBBLE = '0;

  function automatic logic sb_writes(input sb_entry_t e, input sb_reg_t r);
    return e.v & e.wb_en & (e.dest == r);
  endfunction

  function automatic bit hzd_params_ok(input int reg_aw, input int stages, input int sel_w);
    return (reg_aw >= 1) && (reg_aw <= SB_AW) && (stages >= 2) &&
           (sel_w >= 1) && (sel_w < 31) && ((1 << sel_w) > (stages - 1));
  endfunction

endpackage

// File: rtl/hzd_fwd_match.sv
// Forwarding priority comparator for one EXE operand: returns the youngest
// forwardable entry (1..STAGES-2) that writes the operand, else the RF select.
module hzd_fwd_match
  import sarm_hzd_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int SEL_W  = 2
) (
  input  logic             en_i,
  input  sb_reg_t          src_i,
  input  sb_entry_t        entries_i [STAGES],
  output logic [SEL_W-1:0] sel_o
);

  // Scanning oldest-to-youngest lets the smallest index overwrite older matches.
  always_comb begin
    sel_o = SEL_W'(SEL_RF);
    if (en_i) begin
      for (int k = STAGES - 2; k >= 1; k--) begin
        if (sb_writes(entries_i[k], src_i)) sel_o = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/sarm_hazard_scoreboard.sv
// Parametrised hazard scoreboard: ID stall, EXE forwarding selects, flush/hold.
// Optional perf counters (stall_cnt, fwd_cnt) when HAZARD_PERF_CNT_EN is defined.
module sarm_hazard_scoreboard
  import sarm_hzd_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int STAGES = 3,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fwd_en,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic [REG_AW-1:0] id_dest,
  output logic              stall,
  output logic [SEL_W-1:0]  sel_src1,
  output logic [SEL_W-1:0]  sel_src2,
  output logic              busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  if (!hzd_params_ok(REG_AW, STAGES, SEL_W)) begin : g_bad_params
    $error("sarm_hazard_scoreboard: illegal REG_AW/STAGES/SEL_W combination");
  end

  sb_entry_t sb_q [STAGES];
  sb_entry_t sb_d [STAGES];
  sb_entry_t id_e;
  logic      busy_q, busy_d;
  logic      raw_hzd;
  sb_reg_t   id_s1, id_s2;

  assign id_s1 = sb_reg_t'(id_src1);
  assign id_s2 = sb_reg_t'(id_src2);

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    id_e          = SB_BUBBLE;
    id_e.v        = id_valid;
    id_e.wb_en    = id_wb_en;
    id_e.mem_r_en = id_mem_r_en;
    id_e.dest     = sb_reg_t'(id_dest);
    id_e.src1     = id_s1;
    id_e.src2     = id_s2;
    id_e.two_src  = id_two_src;
  end

  // Forwarding covers everything except a load still in EXE; stall-only waits for WB.
  always_comb begin
    raw_hzd = 1'b0;
    if (fwd_en) begin
      raw_hzd = sb_q[0].mem_r_en &
                (sb_writes(sb_q[0], id_s1) | (id_two_src & sb_writes(sb_q[0], id_s2)));
    end else begin
      for (int k = 0; k < STAGES - 1; k++) begin
        raw_hzd = raw_hzd | sb_writes(sb_q[k], id_s1) | (id_two_src & sb_writes(sb_q[k], id_s2));
      end
    end
    stall = id_valid & raw_hzd & ~flush & ~hold;
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) sb_d[k] = sb_q[k];
    if (!hold) begin
      sb_d[0] = (flush || stall) ? SB_BUBBLE : id_e;
      for (int k = 1; k < STAGES; k++) sb_d[k] = sb_q[k-1];
    end
    busy_d = 1'b0;
    for (int k = 0; k < STAGES; k++) busy_d = busy_d | sb_d[k].v;
  end

  // NOTE: the whole entry array is reset, not just v, so no X ever reaches the comparators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) sb_q[k] <= SB_BUBBLE;
      busy_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every entry shift from its pre-edge neighbour.
      for (int k = 0; k < STAGES; k++) sb_q[k] <= sb_d[k];
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  hzd_fwd_match #(.STAGES(STAGES), .SEL_W(SEL_W)) u_fwd_src1 (
    .en_i      (sb_q[0].v & fwd_en),
    .src_i     (sb_q[0].src1),
    .entries_i (sb_q),
    .sel_o     (sel_src1)
  );

  hzd_fwd_match #(.STAGES(STAGES), .SEL_W(SEL_W)) u_fwd_src2 (
    .en_i      (sb_q[0].v & fwd_en & sb_q[0].two_src),
    .src_i     (sb_q[0].src2),
    .entries_i (sb_q),
    .sel_o     (sel_src2)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!hold && ((sel_src1 != '0) || (sel_src2 != '0)) && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_sarm_hazard_scoreboard.sv
// Directed bench for sarm_hazard_scoreboard (default REG_AW=4, STAGES=3, SEL_W=2).
module tb_sarm_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       fwd_en, hold, flush;
  logic       id_valid, id_two_src, id_wb_en, id_mem_r_en;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       stall, busy;
  logic [1:0] sel_src1, sel_src2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sarm_hazard_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .fwd_en      (fwd_en),
    .hold        (hold),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .id_wb_en    (id_wb_en),
    .id_mem_r_en (id_mem_r_en),
    .id_dest     (id_dest),
    .stall       (stall),
    .sel_src1    (sel_src1),
    .sel_src2    (sel_src2),
    .busy        (busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input int v, input int s1, input int s2, input int two,
                        input int wb, input int ld, input int d);
    id_valid    = 1'(v);
    id_src1     = 4'(s1);
    id_src2     = 4'(s2);
    id_two_src  = 1'(two);
    id_wb_en    = 1'(wb);
    id_mem_r_en = 1'(ld);
    id_dest     = 4'(d);
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst0_busy: got %b want 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst0_stall: got %b want 0", stall); end
    n_cmp++; if (sel_src1 !== 2'd0) begin n_bad++; $display("FAIL rst0_sel1: got %0d want 0", sel_src1); end
    tick();
    rst = 1'b1;
    set_id(1, 1, 2, 1, 1, 0, 3);   // ADD r3,r1,r2
    tick();
    set_id(1, 3, 0, 0, 1, 1, 4);   // LDR r4,[r3]
    tick();
    set_id(1, 4, 0, 0, 1, 0, 6);   // ADD r6,r4 : load-use on r4
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL pre_rst_stall: got %b want 1", stall); end
    n_cmp++; if (sel_src1 !== 2'd1) begin n_bad++; $display("FAIL pre_rst_sel1: got %0d want 1", sel_src1); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pre_rst_busy: got %b want 1", busy); end
    #2;
    rst = 1'b0;                     // asynchronous, mid-cycle
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL midrst_stall: got %b want 0", stall); end
    n_cmp++; if (sel_src1 !== 2'd0) begin n_bad++; $display("FAIL midrst_sel1: got %0d want 0", sel_src1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tick();
    rst = 1'b1;
    set_id(1, 0, 0, 0, 1, 1, 9);   // LDR r9 : first issue after reset
    tick();
    set_id(1, 9, 0, 0, 1, 0, 10);  // reader of r9 stalls only if the load sits in entry 0
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL post_rst_entry0_stall: got %b want 1", stall); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL post_rst_busy: got %b want 1", busy); end
    drain();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drained_busy: got %b want 0", busy); end
  endtask

  task automatic test_fwd_alu();
    fwd_en = 1'b1;
    set_id(1, 1, 2, 1, 1, 0, 3);   // ADD r3,r1,r2
    tick();
    set_id(1, 3, 5, 1, 1, 0, 4);   // SUB r4,r3,r5
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL alu_no_stall: got %b want 0", stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (sel_src1 !== 2'd1) begin n_bad++; $display("FAIL alu_sel1: got %0d want 1", sel_src1); end
    n_cmp++; if (sel_src2 !== 2'd0) begin n_bad++; $display("FAIL alu_sel2: got %0d want 0", sel_src2); end
    drain();
  endtask

  task automatic test_load_use();
    fwd_en = 1'b1;
    set_id(1, 0, 0, 0, 1, 1, 2);   // LDR r2,[r0]
    tick();
    set_id(1, 2, 1, 1, 1, 0, 6);   // ADD r6,r2,r1
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ld_stall_c1: got %b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ld_stall_c2: got %b want 0", stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    #1;
    // The load is now in WB (entry 2), which is never forwarded: the RF supplies it.
    n_cmp++; if (sel_src1 !== 2'd0) begin n_bad++; $display("FAIL ld_sel1: got %0d want 0", sel_src1); end
    n_cmp++; if (sel_src2 !== 2'd0) begin n_bad++; $display("FAIL ld_sel2: got %0d want 0", sel_src2); end
    drain();
  endtask

  task automatic test_stall_only();
    fwd_en = 1'b0;
    set_id(1, 0, 0, 0, 1, 0, 7);   // MOV r7
    tick();
    set_id(1, 7, 0, 0, 1, 0, 8);   // ORR r8,r7
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL so_stall_c1: got %b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL so_stall_c2: got %b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL so_stall_c3: got %b want 0", stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (sel_src1 !== 2'd0) begin n_bad++; $display("FAIL so_sel1: got %0d want 0", sel_src1); end
    drain();
  endtask

  task automatic test_flush_hold();
    fwd_en = 1'b1;
    set_id(1, 0, 0, 0, 1, 1, 7);   // LDR r7
    tick();
    set_id(1, 7, 0, 0, 1, 1, 8);   // LDR r8,[r7] hazards, but is flushed
    flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    flush = 1'b0;
    set_id(1, 8, 0, 0, 1, 0, 9);   // ADD r9,r8 would stall if LDR r8 had entered entry 0
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_bubble: got %b want 0", stall); end
    set_id(1, 0, 0, 0, 1, 1, 10);  // LDR r10
    tick();
    set_id(1, 10, 0, 0, 1, 0, 11); // ADD r11,r10
    hold = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL hold_c1_stall: got %b want 0", stall); end
    tick();
    flush = 1'b1;                  // ignored while held
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL hold_c2_stall: got %b want 0", stall); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL hold_c3_stall: got %b want 0", stall); end
    tick();
    hold = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL hold_frozen: got %b want 1", stall); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy: got %b want 1", busy); end
    tick();
    drain();
  endtask

  task automatic test_youngest();
    fwd_en = 1'b1;
    set_id(1, 0, 0, 0, 1, 0, 1);   // ADD r1
    tick();
    set_id(1, 0, 0, 0, 1, 0, 1);   // ADD r1 again
    tick();
    set_id(1, 1, 1, 0, 1, 0, 2);   // SUB r2,r1 (src2 field r1 but unused)
    tick();
    set_id(1, 2, 2, 1, 1, 0, 3);   // ADD r3,r2,r2
    #1;
    n_cmp++; if (sel_src1 !== 2'd1) begin n_bad++; $display("FAIL young_sel1: got %0d want 1", sel_src1); end
    n_cmp++; if (sel_src2 !== 2'd0) begin n_bad++; $display("FAIL young_sel2_unused: got %0d want 0", sel_src2); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL young_stall: got %b want 0", stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (sel_src1 !== 2'd1) begin n_bad++; $display("FAIL same_src_sel1: got %0d want 1", sel_src1); end
    n_cmp++; if (sel_src2 !== 2'd1) begin n_bad++; $display("FAIL same_src_sel2: got %0d want 1", sel_src2); end
    drain();
  endtask

  initial begin
    rst    = 1'b0;
    fwd_en = 1'b1;
    hold   = 1'b0;
    flush  = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_stall_only();
    test_flush_hold();
    test_youngest();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
